// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bus: decode-side inputs, EX-side registered copies,
// stall enables and the bubble counter.
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [2:0]       id_funct3;
    logic             id_funct7b5;
    logic             id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
    logic [1:0]       id_aluop;
    logic             flush, hold;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_funct7b5;
    logic             ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
    logic [1:0]       ex_aluop;
    logic             pc_write_en, ifid_write_en;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_funct3, id_funct7b5, id_branch, id_memread, id_memtoreg, id_memwrite,
               id_alusrc, id_regwrite, id_aluop, flush, hold,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_funct3, ex_funct7b5, ex_branch, ex_memread, ex_memtoreg, ex_memwrite,
               ex_alusrc, ex_regwrite, ex_aluop, pc_write_en, ifid_write_en, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_funct3, id_funct7b5, id_branch, id_memread, id_memtoreg, id_memwrite,
               id_alusrc, id_regwrite, id_aluop, flush, hold,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_funct3, ex_funct7b5, ex_branch, ex_memread, ex_memtoreg, ex_memwrite,
               ex_alusrc, ex_regwrite, ex_aluop, pc_write_en, ifid_write_en, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch squash and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            branch;
        logic            memread;
        logic            memtoreg;
        logic            memwrite;
        logic            alusrc;
        logic            regwrite;
        logic [1:0]      aluop;
    } ex_t;

    ex_t              stage_q, stage_d, capture;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             use_rs2, lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        use_rs2 = ~bus.id_alusrc | bus.id_memwrite;
        lu = bus.id_valid & stage_q.valid & stage_q.memread & (stage_q.rd != 5'd0) &
             ((stage_q.rd == bus.id_rs1) | (use_rs2 & (stage_q.rd == bus.id_rs2)));

        // An empty decode slot never carries live control into EX.
        capture          = '0;
        capture.valid    = bus.id_valid;
        capture.pc       = bus.id_pc;
        capture.rs1_data = bus.id_rs1_data;
        capture.rs2_data = bus.id_rs2_data;
        capture.imm      = bus.id_imm;
        capture.rs1      = bus.id_rs1;
        capture.rs2      = bus.id_rs2;
        capture.rd       = bus.id_rd;
        capture.funct3   = bus.id_funct3;
        capture.funct7b5 = bus.id_funct7b5;
        capture.branch   = bus.id_branch   & bus.id_valid;
        capture.memread  = bus.id_memread  & bus.id_valid;
        capture.memtoreg = bus.id_memtoreg & bus.id_valid;
        capture.memwrite = bus.id_memwrite & bus.id_valid;
        capture.alusrc   = bus.id_alusrc   & bus.id_valid;
        capture.regwrite = bus.id_regwrite & bus.id_valid;
        capture.aluop    = bus.id_aluop & {2{bus.id_valid}};

        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.hold) begin
            stage_d = stage_q;
        end else if (bus.flush) begin
            stage_d = '0;
        end else if (lu) begin
            stage_d      = '0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else begin
            stage_d = capture;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // A flush kills the dependent instruction, so it cancels the stall.
    assign bus.pc_write_en   = ~bus.hold & ~(lu & ~bus.flush);
    assign bus.ifid_write_en = ~bus.hold & ~(lu & ~bus.flush);

    assign bus.ex_valid    = stage_q.valid;
    assign bus.ex_pc       = stage_q.pc;
    assign bus.ex_rs1_data = stage_q.rs1_data;
    assign bus.ex_rs2_data = stage_q.rs2_data;
    assign bus.ex_imm      = stage_q.imm;
    assign bus.ex_rs1      = stage_q.rs1;
    assign bus.ex_rs2      = stage_q.rs2;
    assign bus.ex_rd       = stage_q.rd;
    assign bus.ex_funct3   = stage_q.funct3;
    assign bus.ex_funct7b5 = stage_q.funct7b5;
    assign bus.ex_branch   = stage_q.branch;
    assign bus.ex_memread  = stage_q.memread;
    assign bus.ex_memtoreg = stage_q.memtoreg;
    assign bus.ex_memwrite = stage_q.memwrite;
    assign bus.ex_alusrc   = stage_q.alusrc;
    assign bus.ex_regwrite = stage_q.regwrite;
    assign bus.ex_aluop    = stage_q.aluop;
    assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 2-bit counter
// shares the same stimulus to exercise counter saturation.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32), .CNT_W(16)) ifa ();
    id_ex_stage_if #(.XLEN(32), .CNT_W(2))  ifb ();

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
    id_ex_stage #(.XLEN(32), .CNT_W(2))  dut_small (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifb.id_valid    = ifa.id_valid;
    assign ifb.id_pc       = ifa.id_pc;
    assign ifb.id_rs1_data = ifa.id_rs1_data;
    assign ifb.id_rs2_data = ifa.id_rs2_data;
    assign ifb.id_imm      = ifa.id_imm;
    assign ifb.id_rs1      = ifa.id_rs1;
    assign ifb.id_rs2      = ifa.id_rs2;
    assign ifb.id_rd       = ifa.id_rd;
    assign ifb.id_funct3   = ifa.id_funct3;
    assign ifb.id_funct7b5 = ifa.id_funct7b5;
    assign ifb.id_branch   = ifa.id_branch;
    assign ifb.id_memread  = ifa.id_memread;
    assign ifb.id_memtoreg = ifa.id_memtoreg;
    assign ifb.id_memwrite = ifa.id_memwrite;
    assign ifb.id_alusrc   = ifa.id_alusrc;
    assign ifb.id_regwrite = ifa.id_regwrite;
    assign ifb.id_aluop    = ifa.id_aluop;
    assign ifb.flush       = ifa.flush;
    assign ifb.hold        = ifa.hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1,
                          input logic memread, input logic memwrite, input logic alusrc,
                          input logic regwrite, input logic [1:0] aluop);
        ifa.id_valid    = v;
        ifa.id_pc       = 32'h100 + {27'd0, rd};
        ifa.id_rs1_data = d1;
        ifa.id_rs2_data = 32'h22;
        ifa.id_imm      = 32'h4;
        ifa.id_rs1      = rs1;
        ifa.id_rs2      = rs2;
        ifa.id_rd       = rd;
        ifa.id_funct3   = 3'd0;
        ifa.id_funct7b5 = 1'b0;
        ifa.id_branch   = 1'b0;
        ifa.id_memread  = memread;
        ifa.id_memtoreg = memread;
        ifa.id_memwrite = memwrite;
        ifa.id_alusrc   = alusrc;
        ifa.id_regwrite = regwrite;
        ifa.id_aluop    = aluop;
    endtask

    task automatic lw_x5();
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    endtask

    task automatic add_x6_x5_x7();
        set_id(1'b1, 5'd5, 5'd7, 5'd6, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    endtask

    initial begin
        ifa.flush = 1'b0;
        ifa.hold  = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_valid", ifa.ex_valid, 0);
        chk("reset_bubble_cnt", ifa.bubble_cnt, 0);
        chk("reset_pc_we", ifa.pc_write_en, 1);
        rst_n = 1'b1;

        // Pass-through of an R-type ADD x5,x3,x4
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        tick();
        chk("pass_valid", ifa.ex_valid, 1);
        chk("pass_regwrite", ifa.ex_regwrite, 1);
        chk("pass_aluop", ifa.ex_aluop, 2'b10);
        chk("pass_rs1_data", ifa.ex_rs1_data, 32'h11);
        chk("pass_rd", ifa.ex_rd, 5);
        chk("pass_pc", ifa.ex_pc, 32'h105);
        chk("pass_memread", ifa.ex_memread, 0);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ifa.ex_valid, 0);
        chk("mid_rst_regwrite", ifa.ex_regwrite, 0);
        chk("mid_rst_rd", ifa.ex_rd, 0);
        chk("mid_rst_rs1_data", ifa.ex_rs1_data, 0);
        chk("mid_rst_aluop", ifa.ex_aluop, 0);
        chk("mid_rst_bubble", ifa.bubble_cnt, 0);
        chk("mid_rst_pc_we", ifa.pc_write_en, 1);
        chk("mid_rst_ifid_we", ifa.ifid_write_en, 1);
        tick();
        rst_n = 1'b1;

        // Load-use: LW x5 then ADD x6,x5,x7
        lw_x5();
        tick();
        add_x6_x5_x7();
        #1;
        chk("lu_pc_we", ifa.pc_write_en, 0);
        chk("lu_ifid_we", ifa.ifid_write_en, 0);
        tick();
        chk("lu_bubble_valid", ifa.ex_valid, 0);
        chk("lu_bubble_regwrite", ifa.ex_regwrite, 0);
        chk("lu_bubble_memread", ifa.ex_memread, 0);
        chk("lu_bubble_aluop", ifa.ex_aluop, 0);
        chk("lu_bubble_cnt", ifa.bubble_cnt, 1);
        chk("lu_after_pc_we", ifa.pc_write_en, 1);
        tick();
        chk("lu_issue_valid", ifa.ex_valid, 1);
        chk("lu_issue_rd", ifa.ex_rd, 6);
        chk("lu_issue_rs1", ifa.ex_rs1, 5);
        chk("lu_issue_aluop", ifa.ex_aluop, 2'b10);

        // ADDI x6,x7,1 with rs2 field = 5: no stall
        lw_x5();
        tick();
        set_id(1'b1, 5'd7, 5'd5, 5'd6, 32'h77, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
        #1;
        chk("addi_pc_we", ifa.pc_write_en, 1);
        tick();
        chk("addi_valid", ifa.ex_valid, 1);
        chk("addi_rs1_data", ifa.ex_rs1_data, 32'h77);
        chk("addi_bubble_cnt", ifa.bubble_cnt, 1);

        // SW x5,0(x8): store data dependency stalls
        lw_x5();
        tick();
        set_id(1'b1, 5'd8, 5'd5, 5'd0, 32'h88, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        #1;
        chk("sw_ifid_we", ifa.ifid_write_en, 0);
        tick();
        chk("sw_bubble_valid", ifa.ex_valid, 0);
        chk("sw_bubble_cnt", ifa.bubble_cnt, 2);
        tick();
        chk("sw_issue_memwrite", ifa.ex_memwrite, 1);

        // LW x0 followed by a use of x0: no stall
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        #1;
        chk("x0_pc_we", ifa.pc_write_en, 1);
        tick();
        chk("x0_valid", ifa.ex_valid, 1);
        chk("x0_bubble_cnt", ifa.bubble_cnt, 2);

        // Flush coinciding with load-use
        lw_x5();
        tick();
        add_x6_x5_x7();
        ifa.flush = 1'b1;
        #1;
        chk("flush_pc_we", ifa.pc_write_en, 1);
        chk("flush_ifid_we", ifa.ifid_write_en, 1);
        tick();
        ifa.flush = 1'b0;
        chk("flush_valid", ifa.ex_valid, 0);
        chk("flush_regwrite", ifa.ex_regwrite, 0);
        chk("flush_bubble_cnt", ifa.bubble_cnt, 2);

        // Empty decode slot forces control low
        set_id(1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
        ifa.id_branch = 1'b1;
        tick();
        chk("inv_valid", ifa.ex_valid, 0);
        chk("inv_regwrite", ifa.ex_regwrite, 0);
        chk("inv_memwrite", ifa.ex_memwrite, 0);
        chk("inv_branch", ifa.ex_branch, 0);
        chk("inv_aluop", ifa.ex_aluop, 0);

        // Hold freezes the stage for 3 cycles
        set_id(1'b1, 5'd2, 5'd3, 5'd6, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        tick();
        set_id(1'b1, 5'd1, 5'd0, 5'd9, 32'h99, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        ifa.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rs1_data", ifa.ex_rs1_data, 32'h55);
            chk("hold_rd", ifa.ex_rd, 6);
            chk("hold_pc_we", ifa.pc_write_en, 0);
        end
        ifa.hold = 1'b0;
        tick();
        chk("unhold_rd", ifa.ex_rd, 9);

        // Hold during an active load-use
        lw_x5();
        tick();
        add_x6_x5_x7();
        ifa.hold = 1'b1;
        repeat (2) tick();
        chk("hold_lu_memread", ifa.ex_memread, 1);
        chk("hold_lu_rd", ifa.ex_rd, 5);
        chk("hold_lu_ifid_we", ifa.ifid_write_en, 0);
        chk("hold_lu_bubble_cnt", ifa.bubble_cnt, 2);
        ifa.hold = 1'b0;
        #1;
        chk("hold_lu_release_pc_we", ifa.pc_write_en, 0);
        tick();
        chk("hold_lu_bubble_valid", ifa.ex_valid, 0);
        chk("hold_lu_bubble_cnt2", ifa.bubble_cnt, 3);
        chk("small_cnt_at_3", ifb.bubble_cnt, 3);
        tick();
        chk("hold_lu_issue_rd", ifa.ex_rd, 6);

        // Two more load-use events: wide counter keeps counting, 2-bit saturates
        for (int i = 0; i < 2; i++) begin
            lw_x5();
            tick();
            add_x6_x5_x7();
            tick();
            tick();
        end
        chk("sat_wide_cnt", ifa.bubble_cnt, 5);
        chk("sat_small_cnt", ifb.bubble_cnt, 3);
        chk("sat_small_rd", ifb.ex_rd, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
